l2_port_arbiter: RTL and testbench

//  Shares the single L1->L2 line interface of l2_cache between NUM_REQ upstream line requesters (e.g. I-L1, D-L1).

---
 rtl/cache_pkg.sv | 20 ++
 rtl/l2_port_arbiter_rr_pick.sv | 29 ++
 rtl/l2_port_arbiter.sv | 133 +++++++++++++
 tb/tb_l2_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache slice: arbiter FSM states,
// the default line type and the perf-counter width.
package cache_pkg;

    localparam int LINE_W_DEFAULT = 256;
    localparam int PERF_CNT_W     = 32;

    typedef logic [LINE_W_DEFAULT-1:0] line_t;

    typedef logic [1:0] arb_state_e;
    localparam arb_state_e IDLE  = 2'd0;
    localparam arb_state_e ISSUE = 2'd1;
    localparam arb_state_e WAIT  = 2'd2;

    // Modulo wrap used when walking requesters from the round-robin pointer.
    function automatic int rr_wrap(input int idx, input int n);
        return idx % n;
    endfunction

endpackage

// File: rtl/l2_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Searches from rr_ptr+1 upward
// (wrapping) and returns a one-hot grant plus an any-request flag.
module rr_pick
    import cache_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               any
);

    always_comb begin
        logic [PTR_W-1:0] idx;
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = PTR_W'(rr_wrap(int'(rr_ptr) + k, NUM_REQ));
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares the single L1->L2 line interface between NUM_REQ
// requesters, one transaction in flight. Optional L2ARB_PERF_CNT_EN builds grant counters.
module l2_port_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int L1_LINE_W = LINE_W_DEFAULT,
    parameter int NUM_REQ   = 2,
    parameter int CNT_W     = PERF_CNT_W
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                up_req_valid,
    output logic [NUM_REQ-1:0]                up_req_ready,
    input  logic [NUM_REQ-1:0]                up_req_rw,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]    up_req_addr,
    input  logic [NUM_REQ-1:0][L1_LINE_W-1:0] up_req_wline,
    output logic [NUM_REQ-1:0]                up_resp_valid,
    output logic [L1_LINE_W-1:0]              up_resp_rline,
    output logic                              dn_req_valid,
    input  logic                              dn_req_ready,
    output logic                              dn_req_rw,
    output logic [ADDR_W-1:0]                 dn_req_addr,
    output logic [L1_LINE_W-1:0]              dn_req_wline,
    input  logic                              dn_resp_valid,
    input  logic [L1_LINE_W-1:0]              dn_resp_rline,
    output logic [NUM_REQ-1:0][CNT_W-1:0]     perf_grant_cnt
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_e           state;
    logic [PTR_W-1:0]     owner;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     grant_idx;
    logic [NUM_REQ-1:0]   grant;
    logic                 any;
    logic                 accept;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req    (up_req_valid),
        .rr_ptr (rr_ptr),
        .grant  (grant),
        .any    (any)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_idx = PTR_W'(i);
        end
    end

    assign accept        = (state == IDLE) && any;
    assign up_req_ready  = (state == IDLE) ? grant : '0;
    assign dn_req_valid  = (state == ISSUE);
    assign up_resp_rline = dn_resp_rline;

    // Responses are only steered while a transaction is outstanding.
    always_comb begin
        up_resp_valid = '0;
        if ((state == WAIT) && dn_resp_valid) up_resp_valid[owner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= PTR_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner  <= grant_idx;
                        rr_ptr <= grant_idx;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (dn_req_ready) state <= WAIT;
                end
                WAIT: begin
                    if (dn_resp_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request fields are captured once at accept and held through ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_req_rw    <= 1'b0;
            dn_req_addr  <= '0;
            dn_req_wline <= '0;
        end else if (accept) begin
            dn_req_rw    <= up_req_rw[grant_idx];
            dn_req_addr  <= up_req_addr[grant_idx];
            dn_req_wline <= up_req_wline[grant_idx];
        end
    end

`ifdef L2ARB_PERF_CNT_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] grant_cnt;

    // Saturating per-requester grant counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept && grant[i] && (grant_cnt[i] != '1)) begin
                    grant_cnt[i] <= grant_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign perf_grant_cnt = grant_cnt;
`else
    assign perf_grant_cnt = '0;
`endif

`ifndef SYNTHESIS
    spurious_resp_chk: assert property (@(posedge clk) disable iff (!rst_n)
        dn_resp_valid |-> (state == WAIT))
        else $warning("l2_port_arbiter: dn_resp_valid outside WAIT ignored");
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: table of line transactions plus
// hand sequences for reset, spurious response and perf counters.
module tb_l2_port_arbiter;
    import cache_pkg::*;

    localparam int ADDR_W = 32;
    localparam int LW     = 256;
    localparam int NR     = 2;
    localparam int CW     = 32;

    logic                     clk;
    logic                     rst_n;
    logic [NR-1:0]            up_req_valid;
    logic [NR-1:0]            up_req_ready;
    logic [NR-1:0]            up_req_rw;
    logic [NR-1:0][ADDR_W-1:0] up_req_addr;
    logic [NR-1:0][LW-1:0]    up_req_wline;
    logic [NR-1:0]            up_resp_valid;
    logic [LW-1:0]            up_resp_rline;
    logic                     dn_req_valid;
    logic                     dn_req_ready;
    logic                     dn_req_rw;
    logic [ADDR_W-1:0]        dn_req_addr;
    logic [LW-1:0]            dn_req_wline;
    logic                     dn_resp_valid;
    logic [LW-1:0]            dn_resp_rline;
    logic [NR-1:0][CW-1:0]    perf_grant_cnt;

    l2_port_arbiter #(
        .ADDR_W (ADDR_W), .L1_LINE_W (LW), .NUM_REQ (NR), .CNT_W (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .up_req_valid   (up_req_valid),
        .up_req_ready   (up_req_ready),
        .up_req_rw      (up_req_rw),
        .up_req_addr    (up_req_addr),
        .up_req_wline   (up_req_wline),
        .up_resp_valid  (up_resp_valid),
        .up_resp_rline  (up_resp_rline),
        .dn_req_valid   (dn_req_valid),
        .dn_req_ready   (dn_req_ready),
        .dn_req_rw      (dn_req_rw),
        .dn_req_addr    (dn_req_addr),
        .dn_req_wline   (dn_req_wline),
        .dn_resp_valid  (dn_resp_valid),
        .dn_resp_rline  (dn_resp_rline),
        .perf_grant_cnt (perf_grant_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic                 do_reset;
        logic [1:0]           new_req;
        logic [1:0]           rw;
        logic [1:0][31:0]     addr;
        logic [7:0]           wbyte;
        int                   exp_owner;
        int                   lat;
        int                   stall;
    } txn_t;

    int checks = 0;
    int errors = 0;
    int resp_n = 0;

    logic [NR-1:0]             pend;
    logic [NR-1:0]             m_rw;
    logic [NR-1:0][ADDR_W-1:0] m_addr;
    logic [NR-1:0][LW-1:0]     m_wline;

    txn_t tbl[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        up_req_valid = pend;
        up_req_rw    = m_rw;
        up_req_addr  = m_addr;
        up_req_wline = m_wline;
    endtask

    task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int i);
        return 2'(1 << i);
    endfunction

    task automatic doReset();
        rst_n         = 1'b0;
        pend          = '0;
        dn_req_ready  = 1'b0;
        dn_resp_valid = 1'b0;
        applyStimulus();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic runTxn(input txn_t t);
        logic [LW-1:0] rline;
        if (t.do_reset) doReset();
        for (int i = 0; i < NR; i++) begin
            if (t.new_req[i]) begin
                pend[i]    = 1'b1;
                m_rw[i]    = t.rw[i];
                m_addr[i]  = t.addr[i];
                m_wline[i] = {32{t.wbyte}};
            end
        end
        applyStimulus();
        #1;
        checkOutput("up_req_ready", LW'(up_req_ready), LW'(oh(t.exp_owner)));
        tick();
        pend[t.exp_owner] = 1'b0;
        applyStimulus();
        #1;
        checkOutput("dn_req_valid", LW'(dn_req_valid), LW'(1));
        checkOutput("dn_req_rw", LW'(dn_req_rw), LW'(m_rw[t.exp_owner]));
        checkOutput("dn_req_addr", LW'(dn_req_addr), LW'(m_addr[t.exp_owner]));
        checkOutput("dn_req_wline", dn_req_wline, m_wline[t.exp_owner]);
        checkOutput("ready_in_issue", LW'(up_req_ready), LW'(0));
        for (int s = 0; s < t.stall; s++) begin
            tick();
            checkOutput("stall_valid", LW'(dn_req_valid), LW'(1));
            checkOutput("stall_addr", LW'(dn_req_addr), LW'(m_addr[t.exp_owner]));
            checkOutput("stall_no_ready", LW'(up_req_ready), LW'(0));
        end
        dn_req_ready = 1'b1;
        tick();
        dn_req_ready = 1'b0;
        #1;
        checkOutput("dn_req_valid_wait", LW'(dn_req_valid), LW'(0));
        for (int c = 1; c < t.lat; c++) tick();
        checkOutput("resp_early", LW'(up_resp_valid), LW'(0));
        resp_n++;
        rline         = {8{32'hD000_0000 + 32'(resp_n)}};
        dn_resp_valid = 1'b1;
        dn_resp_rline = rline;
        #1;
        checkOutput("up_resp_valid", LW'(up_resp_valid), LW'(oh(t.exp_owner)));
        checkOutput("up_resp_rline", up_resp_rline, rline);
        tick();
        dn_resp_valid = 1'b0;
        #1;
        checkOutput("resp_pulse_end", LW'(up_resp_valid), LW'(0));
    endtask

    initial begin
        txn_t t;
        logic [CW-1:0] exp0, exp1;

        tbl[0] = '{1'b1, 2'b01, 2'b00, {32'h0, 32'h0000_0100}, 8'h00, 0, 4, 0};
        tbl[1] = '{1'b1, 2'b11, 2'b00, {32'h2000, 32'h1000}, 8'h11, 0, 2, 0};
        tbl[2] = '{1'b0, 2'b01, 2'b01, {32'h0, 32'h3000}, 8'h3C, 1, 1, 0};
        tbl[3] = '{1'b0, 2'b00, 2'b00, {32'h0, 32'h0}, 8'h00, 0, 3, 0};
        tbl[4] = '{1'b0, 2'b10, 2'b10, {32'h40, 32'h0}, 8'hA5, 1, 2, 0};
        tbl[5] = '{1'b0, 2'b11, 2'b00, {32'h5000, 32'h4000}, 8'h77, 0, 1, 5};
        tbl[6] = '{1'b0, 2'b00, 2'b00, {32'h0, 32'h0}, 8'h00, 1, 2, 0};

        pend          = '0;
        m_rw          = '0;
        m_addr        = '0;
        m_wline       = '0;
        dn_req_ready  = 1'b0;
        dn_resp_valid = 1'b0;
        dn_resp_rline = '0;
        rst_n         = 1'b0;
        applyStimulus();
        repeat (2) tick();
        checkOutput("reset_dn_valid", LW'(dn_req_valid), LW'(0));
        checkOutput("reset_dn_addr", LW'(dn_req_addr), LW'(0));
        checkOutput("reset_ready", LW'(up_req_ready), LW'(0));
        checkOutput("reset_resp", LW'(up_resp_valid), LW'(0));
        checkOutput("reset_perf", LW'(perf_grant_cnt), LW'(0));
        rst_n = 1'b1;
        tick();

        for (int n = 0; n < 7; n++) runTxn(tbl[n]);

        // Spurious response while idle must not reach any requester.
        doReset();
        dn_resp_valid = 1'b1;
        dn_resp_rline = {8{32'hBAD0_BAD0}};
        #1;
        checkOutput("spurious_resp", LW'(up_resp_valid), LW'(0));
        checkOutput("spurious_rline", up_resp_rline, {8{32'hBAD0_BAD0}});
        tick();
        dn_resp_valid = 1'b0;
        #1;
        checkOutput("spurious_idle", LW'(dn_req_valid), LW'(0));

        // Reset while waiting for L2 drops the transaction.
        pend[1]   = 1'b1;
        m_rw[1]   = 1'b0;
        m_addr[1] = 32'h7000;
        applyStimulus();
        tick();
        pend = '0;
        applyStimulus();
        dn_req_ready = 1'b1;
        tick();
        dn_req_ready = 1'b0;
        #1;
        checkOutput("pre_reset_addr", LW'(dn_req_addr), LW'(32'h7000));
        rst_n         = 1'b0;
        dn_resp_valid = 1'b1;
        #1;
        checkOutput("midrst_resp", LW'(up_resp_valid), LW'(0));
        checkOutput("midrst_dn_valid", LW'(dn_req_valid), LW'(0));
        checkOutput("midrst_dn_addr", LW'(dn_req_addr), LW'(0));
        checkOutput("midrst_ready", LW'(up_req_ready), LW'(0));
        tick();
        dn_resp_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        t = '{1'b0, 2'b11, 2'b00, {32'h9100, 32'h9000}, 8'h00, 0, 1, 0};
        runTxn(t);
        t = '{1'b0, 2'b00, 2'b00, {32'h0, 32'h0}, 8'h00, 1, 1, 0};
        runTxn(t);

        // Grant counters: 10 grants to req0, 7 to req1.
        doReset();
        for (int p = 0; p < 7; p++) begin
            t = '{1'b0, 2'b11, 2'b00, {32'h100 + 32'(p), 32'h200 + 32'(p)}, 8'h00, 0, 1, 0};
            runTxn(t);
            t = '{1'b0, 2'b00, 2'b00, {32'h0, 32'h0}, 8'h00, 1, 1, 0};
            runTxn(t);
        end
        for (int p = 0; p < 3; p++) begin
            t = '{1'b0, 2'b01, 2'b00, {32'h0, 32'h300 + 32'(p)}, 8'h00, 0, 1, 0};
            runTxn(t);
        end
`ifdef L2ARB_PERF_CNT_EN
        exp0 = 32'd10;
        exp1 = 32'd7;
`else
        exp0 = 32'd0;
        exp1 = 32'd0;
`endif
        checkOutput("perf_cnt0", LW'(perf_grant_cnt[0]), LW'(exp0));
        checkOutput("perf_cnt1", LW'(perf_grant_cnt[1]), LW'(exp1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
